vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing from the 25 MHz pixel clock.
- Drives the DrawX/DrawY/blank inputs of the sprite ROM/palette render stages directly downstream.
- Provides hsync/vsync delayed to match the render stages' pipeline latency (ROM read + registered RGB), plus a frame_start pulse for game-state update logic.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- PIPE_DLY, 2, cycles of delay applied to hs/vs; 0 = no delay

Ports:
- vga_clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- DrawX  out  10  current horizontal count (0..799)
- DrawY  out  10  current vertical count (0..524)
- blank  out  1  display enable; 1 = visible pixel (DrawX<640 && DrawY<480)
- hs  out  1  hsync, active low, delayed PIPE_DLY cycles
- vs  out  1  vsync, active low, delayed PIPE_DLY cycles
- frame_start  out  1  one-cycle pulse while DrawX==0 && DrawY==0
- frame_count  out  8  frames completed, modulo 256

Behaviour:
- One clock (vga_clk); reset is asynchronous and active-high.
- Reset values: DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_start=0, frame_count=0, and all delay-line stages 1.
- Counters:
  - hc increments every cycle.
  - At hc==H_TOTAL-1, hc wraps to 0 and vc increments.
  - At hc==H_TOTAL-1 && vc==V_TOTAL-1, both counters wrap to 0 in the same cycle.
- DrawX/DrawY are the counter registers themselves.
- blank, frame_start and raw sync are registered, each computed from the next-state counter values, so they align with DrawX/DrawY in the same cycle. No combinational path from the counters to these outputs.
- Post-reset exception: in the first cycle after reset release, DrawX=DrawY=0 but blank=0 and frame_start=0. Alignment holds from the first rising edge onward.
- Raw sync decode:
  - hs_raw = 0 iff H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC (656..751).
  - vs_raw = 0 iff V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC (490..491).
- hs/vs output: raw sync passed through a PIPE_DLY-stage shift register. With PIPE_DLY=2, the hs falling edge appears 2 cycles after DrawX first reads 656.
- blank and DrawX/DrawY are never delayed; downstream stages absorb their own latency.
- frame_count increments on the cycle frame_start is registered high, and wraps 255->0.
- Reset mid-frame: counters, delay line and all outputs return immediately (asynchronously) to their reset values. On release, the raster restarts at (0,0).
- Width rules: counters are 10 bits. All comparisons are unsigned, against constants of matching width.

Optional Feature:
- Macro: VGA_FRAME_COUNTER_EN.
- Defined: frame_count is implemented as described above.
- Undefined: frame_count is tied to 0 and no counter flops are generated. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - H_TOTAL, V_TOTAL and the sync start/end constants derived from the default parameters;
  - typedef coord_t = logic [9:0].
- One sub-module, vga_sync_delay: parameterised-depth shift register for {hs,vs}, reset to 1, pass-through when depth is 0.

Test Plan:
- Assert reset for 5 cycles, release -> DrawX=0, DrawY=0, blank=0, hs=vs=1 during reset; blank=1 at DrawX=1, DrawY=0 after the first edge.
- Run one line -> blank 1 at DrawX=639, 0 at DrawX=640; hs low exactly 96 cycles, starting 2 cycles after DrawX=656 (PIPE_DLY=2).
- Run to (799,524) -> next cycle (0,0) with frame_start=1 for exactly one cycle; vs low exactly 1600 cycles per frame.
- Check vertical boundary -> blank=0 for the whole line at DrawY=480; blank=1 at DrawY=479, DrawX=0..639.
- Assert reset at (300,200) mid-frame -> all outputs at reset values immediately; after release, frame restarts at (0,0) and the next frame_start occurs 420000 cycles later.
- With VGA_FRAME_COUNTER_EN defined, run 257 frames -> frame_count wraps 255->0->1; without the macro, frame_count stays 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster constants and coordinate type for the 640x480@60 VGA timing generator.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned HS_START = 656;
  localparam int unsigned HS_END   = 752;
  localparam int unsigned VS_START = 490;
  localparam int unsigned VS_END   = 492;

  function automatic coord_t to_coord(input int unsigned v);
    return coord_t'(v);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Depth-stage shift register for {hs, vs}; stages reset to 1 (inactive), Depth 0 passes through.
module vga_sync_delay #(
  parameter int unsigned Depth = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sync_raw,
  output logic [1:0] sync_dly
);

  if (Depth == 0) begin : g_bypass
    assign sync_dly = sync_raw;
  end else begin : g_pipe
    logic [1:0] stage_q [Depth];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < Depth; i++) stage_q[i] <= 2'b11;
      end else begin
        stage_q[0] <= sync_raw;
        for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign sync_dly = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, registered blank/frame_start/raw sync, delayed hs/vs.
// Define VGA_FRAME_COUNTER_EN to implement frame_count; otherwise it is tied to 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam coord_t HLast   = to_coord(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t VLast   = to_coord(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t HVis    = to_coord(H_VIS);
  localparam coord_t VVis    = to_coord(V_VIS);
  localparam coord_t HsStart = to_coord(H_VIS + H_FP);
  localparam coord_t HsEnd   = to_coord(H_VIS + H_FP + H_SYNC);
  localparam coord_t VsStart = to_coord(V_VIS + V_FP);
  localparam coord_t VsEnd   = to_coord(V_VIS + V_FP + V_SYNC);

  coord_t hc_q, vc_q, hc_d, vc_d;
  logic   blank_q, frame_start_q, hs_raw_q, vs_raw_q;
  logic   blank_d, frame_start_d, hs_raw_d, vs_raw_d;
  logic [1:0] sync_dly;

  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == HLast) begin
      hc_d = '0;
      vc_d = (vc_q == VLast) ? '0 : vc_q + 10'd1;
    end
  end

  // Flags decode the next-state counters so, once registered, they line up with DrawX/DrawY.
  always_comb begin
    blank_d       = (hc_d < HVis) && (vc_d < VVis);
    frame_start_d = (hc_d == '0) && (vc_d == '0);
    hs_raw_d      = !((hc_d >= HsStart) && (hc_d < HsEnd));
    vs_raw_d      = !((vc_d >= VsStart) && (vc_d < VsEnd));
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q          <= '0;
      vc_q          <= '0;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      hs_raw_q      <= 1'b1;
      vs_raw_q      <= 1'b1;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
    end
  end

  vga_sync_delay #(
    .Depth(PIPE_DLY)
  ) u_sync_delay (
    .clk      (vga_clk),
    .rst      (reset),
    .sync_raw ({hs_raw_q, vs_raw_q}),
    .sync_dly (sync_dly)
  );

`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frame_count_q;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (frame_start_d) begin
      frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign hs          = sync_dly[1];
  assign vs          = sync_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a shrunken raster DUT for whole-frame and wrap coverage plus a full 640x480 DUT for one line.
module tb_vga_timing_gen;

  localparam int SHV = 8, SHF = 2, SHS = 4, SHB = 2;
  localparam int SVV = 5, SVF = 1, SVS = 2, SVB = 2;
  localparam int SF  = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);
  localparam int DLY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [9:0] s_x, s_y, b_x, b_y;
  logic       s_blank, s_hs, s_vs, s_fs, b_blank, b_hs, b_vs, b_fs;
  logic [7:0] s_fc, b_fc;

  int compared   = 0;
  int mismatched = 0;
  int t          = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .PIPE_DLY(DLY)
  ) u_small (
    .vga_clk(clk), .reset(rst), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing_gen u_full (
    .vga_clk(clk), .reset(rst), .DrawX(b_x), .DrawY(b_y), .blank(b_blank),
    .hs(b_hs), .vs(b_vs), .frame_start(b_fs), .frame_count(b_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Reference: position is simply (cycles since release) mod frame length.
  task automatic check_raster(input string name, input int hv, input int hf, input int hsw,
                              input int hb, input int vv, input int vf, input int vsw,
                              input int vb, input logic [9:0] x, input logic [9:0] y,
                              input logic bl, input logic h, input logic v, input logic fs,
                              input logic [7:0] fc);
    int ht, vt, f, p, q, ex, ey, qx, qy, efc;
    logic ebl, efs, ehs, evs;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    f   = ht * vt;
    p   = t % f;
    ex  = p % ht;
    ey  = p / ht;
    ebl = (t > 0) && (ex < hv) && (ey < vv);
    efs = (t > 0) && (p == 0);
    ehs = 1'b1;
    evs = 1'b1;
    if (t >= DLY) begin
      q   = (t - DLY) % f;
      qx  = q % ht;
      qy  = q / ht;
      ehs = !(qx >= hv + hf && qx < hv + hf + hsw);
      evs = !(qy >= vv + vf && qy < vv + vf + vsw);
    end
`ifdef VGA_FRAME_COUNTER_EN
    efc = (t / f) % 256;
`else
    efc = 0;
`endif
    chk({name, ".DrawX"}, 32'(x), ex);
    chk({name, ".DrawY"}, 32'(y), ey);
    chk({name, ".blank"}, 32'(bl), 32'(ebl));
    chk({name, ".hs"}, 32'(h), 32'(ehs));
    chk({name, ".vs"}, 32'(v), 32'(evs));
    chk({name, ".frame_start"}, 32'(fs), 32'(efs));
    chk({name, ".frame_count"}, 32'(fc), efc);
  endtask

  task automatic check_all();
    check_raster("small", SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB,
                 s_x, s_y, s_blank, s_hs, s_vs, s_fs, s_fc);
    check_raster("full", 640, 16, 96, 48, 480, 10, 2, 33,
                 b_x, b_y, b_blank, b_hs, b_vs, b_fs, b_fc);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".small.x"}, 32'(s_x), 0);
    chk({tag, ".small.y"}, 32'(s_y), 0);
    chk({tag, ".small.blank"}, 32'(s_blank), 0);
    chk({tag, ".small.hs"}, 32'(s_hs), 1);
    chk({tag, ".small.vs"}, 32'(s_vs), 1);
    chk({tag, ".small.fs"}, 32'(s_fs), 0);
    chk({tag, ".small.fc"}, 32'(s_fc), 0);
    chk({tag, ".full.x"}, 32'(b_x), 0);
    chk({tag, ".full.y"}, 32'(b_y), 0);
    chk({tag, ".full.blank"}, 32'(b_blank), 0);
    chk({tag, ".full.hs"}, 32'(b_hs), 1);
    chk({tag, ".full.vs"}, 32'(b_vs), 1);
    chk({tag, ".full.fs"}, 32'(b_fs), 0);
    chk({tag, ".full.fc"}, 32'(b_fc), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
    check_all();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    t   = 0;
    #1;
    check_all();
  endtask

  // Assert reset a few ns after an edge so the check below sees the asynchronous response.
  task automatic async_reset(input string tag, input int hold);
    #1;
    rst = 1'b1;
    #1;
    check_reset(tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_reset({tag, ".hold"});
    end
  endtask

  initial begin
    int hs_low, hs_first, vs_low, fs_cnt, found;

    repeat (5) begin
      @(posedge clk);
      #1;
      check_reset("por");
    end
    release_reset();

    hs_low = 0; hs_first = -1; vs_low = 0; fs_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (t == 1) begin
        chk("first_edge.x", 32'(b_x), 1);
        chk("first_edge.blank", 32'(b_blank), 1);
      end
      if (t == 639) chk("blank_x639", 32'(b_blank), 1);
      if (t == 640) chk("blank_x640", 32'(b_blank), 0);
      if (!b_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = t;
      end
      if (t <= SF) begin
        if (!s_vs) vs_low++;
        if (s_fs) fs_cnt++;
      end
    end
    chk("full.hs_low_cycles", hs_low, 96);
    chk("full.hs_fall_t", hs_first, 656 + DLY);
    chk("small.vs_low_cycles", vs_low, SVS * (SHV + SHF + SHS + SHB));
    chk("small.fs_per_frame", fs_cnt, 1);

    // Directed mid-frame reset at a fixed small-raster point, then time to next frame_start.
    found = 0;
    for (int i = 0; i < 2 * SF && found == 0; i++) begin
      step();
      if (s_x == 10'd7 && s_y == 10'd3) found = 1;
    end
    chk("reach_7_3", found, 1);
    async_reset("mid_reset", 2);
    release_reset();
    found = 0;
    for (int i = 0; i < 2 * SF && found == 0; i++) begin
      step();
      if (s_fs) found = 1;
    end
    chk("restart_fs_delay", found != 0 ? t : -1, SF);

    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(1, 3 * SF));
      for (int i = 0; i < n; i++) step();
      async_reset("rand_reset", int'($urandom_range(0, 4)));
      release_reset();
    end

    for (int i = 0; i < 258 * SF + 3; i++) begin
      step();
      if (t == 256 * SF) begin
`ifdef VGA_FRAME_COUNTER_EN
        chk("fc_wrap_to_0", 32'(s_fc), 0);
`else
        chk("fc_tied_0", 32'(s_fc), 0);
`endif
      end
      if (t == 257 * SF) begin
`ifdef VGA_FRAME_COUNTER_EN
        chk("fc_after_wrap", 32'(s_fc), 1);
`else
        chk("fc_tied_0_late", 32'(s_fc), 0);
`endif
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
